// File: rtl/pipeline_ctrl_n_pkg.sv
// pipeline_ctrl_n_pkg: shared FSM states, stage indices and stall polarity for the hazard controller
package pipeline_ctrl_n_pkg;
    typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_e;
    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;
    localparam int FCNT_W = 4;
endpackage

// File: rtl/pipeline_ctrl_n_if.sv
// pipeline_ctrl_n_if: datapath <-> hazard controller signal bundle
interface pipeline_ctrl_n_if #(
    parameter int NUM_STAGES = 6,
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 32
);
    logic [NUM_STAGES-1:0] stall_req;
    logic                  flush_req;
    logic [ADDR_W-1:0]     flush_target;
    logic [NUM_STAGES-1:0] stall;
    logic [NUM_STAGES-1:0] bubble;
    logic [NUM_STAGES-1:0] flush;
    logic                  redirect_valid;
    logic [ADDR_W-1:0]     redirect_pc;
    logic                  busy_flushing;
    logic                  deadlock;
    logic [CNT_W-1:0]      stall_cycles;
    modport master (
        output stall_req, flush_req, flush_target,
        input  stall, bubble, flush, redirect_valid, redirect_pc, busy_flushing, deadlock, stall_cycles
    );
    modport slave (
        input  stall_req, flush_req, flush_target,
        output stall, bubble, flush, redirect_valid, redirect_pc, busy_flushing, deadlock, stall_cycles
    );
endinterface

// File: rtl/pipeline_ctrl_n_stall_mask_gen.sv
// pipeline_ctrl_n_stall_mask_gen: prefix stall mask (a request at stage k freezes 0..k) and bubble points
module pipeline_ctrl_n_stall_mask_gen
    import pipeline_ctrl_n_pkg::*;
#(
    parameter int NUM_STAGES = 6
) (
    input  logic [NUM_STAGES-1:0] stall_req_i,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic [NUM_STAGES-1:0] bubble_o
);
    always_comb begin
        stall_o[NUM_STAGES-1] = stall_req_i[NUM_STAGES-1];
        for (int i = NUM_STAGES - 2; i >= 0; i--) stall_o[i] = stall_o[i+1] | stall_req_i[i];
    end
    // a bubble enters where a stalled stage feeds a moving one
    assign bubble_o = {stall_o[NUM_STAGES-2:0] & ~stall_o[NUM_STAGES-1:1], NO_STOP};
endmodule

// File: rtl/pipeline_ctrl_n.sv
// pipeline_ctrl_n: stall merge, bubble marking, registered flush/redirect sequence,
// stall watchdog and stall-cycle counter for an N-stage in-order pipeline
module pipeline_ctrl_n
    import pipeline_ctrl_n_pkg::*;
#(
    parameter int NUM_STAGES   = 6,
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 1,
    parameter int WDOG_LIMIT   = 1024,
    parameter int CNT_W        = 32
) (
    input logic clk,
    input logic rst,
    pipeline_ctrl_n_if.slave bus
);
    localparam int WW = (WDOG_LIMIT > 0) ? $clog2(WDOG_LIMIT + 1) : 1;
    localparam logic [WW-1:0] WLIM = WW'(WDOG_LIMIT);
    localparam logic [FCNT_W-1:0] FLAST = FCNT_W'(FLUSH_CYCLES - 1);

    state_e              state_q, state_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic [WW-1:0]       wcnt_q, wcnt_d;
    logic                dl_q, dl_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_STAGES-1:0] mask, bub, stall;
    logic                run;

    pipeline_ctrl_n_stall_mask_gen #(.NUM_STAGES(NUM_STAGES)) u_mask (
        .stall_req_i (bus.stall_req),
        .stall_o     (mask),
        .bubble_o    (bub)
    );

    assign run   = state_q == ST_RUN;
    assign stall = (rst || !run) ? '0 : mask;

    assign bus.stall          = stall;
    assign bus.bubble         = (rst || !run) ? '0 : bub;
    // WB keeps its contents during a flush so the oldest instruction retires
    assign bus.flush          = (rst || run) ? '0 : {NO_STOP, {(NUM_STAGES-1){STOP}}};
    assign bus.redirect_valid = !rst && !run && fcnt_q == FLAST;
    assign bus.busy_flushing  = !rst && !run;
    assign bus.redirect_pc    = rst ? '0 : pc_q;
    assign bus.deadlock       = !rst && dl_q;
    assign bus.stall_cycles   = rst ? '0 : cnt_q;

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        pc_d    = pc_q;
        if (run) begin
            if (bus.flush_req) begin
                state_d = ST_FLUSH;
                fcnt_d  = FLAST;
                pc_d    = bus.flush_target;
            end
        end else begin
            state_d = (fcnt_q == '0) ? ST_RUN : ST_FLUSH;
            fcnt_d  = (fcnt_q == '0) ? fcnt_q : fcnt_q - FCNT_W'(1);
        end
        wcnt_d = (stall == '0) ? '0 : (wcnt_q == WLIM) ? wcnt_q : wcnt_q + WW'(1);
        dl_d   = dl_q | ((WDOG_LIMIT != 0) && wcnt_d == WLIM);
        cnt_d  = cnt_q + CNT_W'(|stall);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            fcnt_q  <= '0;
            wcnt_q  <= '0;
            dl_q    <= 1'b0;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            wcnt_q  <= wcnt_d;
            dl_q    <= dl_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_pipeline_ctrl_n.sv
// tb_pipeline_ctrl_n: directed vector table, watchdog/reset sequences and a randomized
// run checked against a behavioural model of the hazard controller
module tb_pipeline_ctrl_n;
    localparam int N   = 6;
    localparam int FC  = 2;
    localparam int LIM = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    pipeline_ctrl_n_if #(.NUM_STAGES(N), .ADDR_W(32), .CNT_W(32)) bus ();

    pipeline_ctrl_n #(
        .NUM_STAGES(N), .ADDR_W(32), .FLUSH_CYCLES(FC), .WDOG_LIMIT(LIM), .CNT_W(32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // model state: m_left = FLUSH cycles remaining including the current one (0 = running)
    int          m_left = 0;
    int          m_w    = 0;
    bit          m_dl   = 0;
    logic [31:0] m_pc   = '0;
    logic [31:0] m_cnt  = '0;

    typedef struct {
        logic        r;
        logic [5:0]  req;
        logic        fr;
        logic [31:0] tgt;
        logic [5:0]  st, bu, fl;
        logic        rv, bz, dl;
        logic [31:0] pc, cnt;
    } vec_t;
    vec_t vecs[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h want=%0h", name, $time, act, exp);
        end
    endtask

    function automatic int top_req(input logic [5:0] r);
        int h = -1;
        for (int i = 0; i < N; i++) if (r[i]) h = i;
        return h;
    endfunction

    function automatic logic [5:0] m_stall();
        int h = top_req(bus.stall_req);
        if (rst || m_left > 0 || h < 0) return '0;
        return 6'((1 << (h + 1)) - 1);
    endfunction

    function automatic logic [5:0] m_bubble();
        int h = top_req(bus.stall_req);
        if (rst || m_left > 0 || h < 0 || h == N - 1) return '0;
        return 6'(1 << (h + 1));
    endfunction

    task automatic model_edge();
        logic [5:0] s = m_stall();
        if (rst) begin
            m_left = 0; m_w = 0; m_dl = 0; m_pc = '0; m_cnt = '0;
        end else begin
            if (s != 0) m_cnt++;
            m_w = (s != 0) ? ((m_w < LIM) ? m_w + 1 : LIM) : 0;
            if (LIM > 0 && m_w == LIM) m_dl = 1;
            if (m_left > 0) m_left--;
            else if (bus.flush_req) begin
                m_left = FC;
                m_pc   = bus.flush_target;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model();
        bit fl = !rst && m_left > 0;
        chk("m_stall", bus.stall, m_stall());
        chk("m_bubble", bus.bubble, m_bubble());
        chk("m_flush", bus.flush, fl ? 6'b011111 : 6'b0);
        chk("m_redirect_valid", bus.redirect_valid, fl && m_left == FC);
        chk("m_busy", bus.busy_flushing, fl);
        chk("m_redirect_pc", bus.redirect_pc, rst ? 32'h0 : m_pc);
        chk("m_deadlock", bus.deadlock, !rst && m_dl);
        chk("m_stall_cycles", bus.stall_cycles, rst ? 32'h0 : m_cnt);
    endtask

    task automatic drive(input logic r, input logic [5:0] req, input logic fr, input logic [31:0] tgt);
        rst = r;
        bus.stall_req = req;
        bus.flush_req = fr;
        bus.flush_target = tgt;
    endtask

    initial begin
        drive(1'b1, '0, 1'b0, '0);
        vecs[0]  = '{1, 6'b000000, 0, 32'h0,        6'b000000, 6'b000000, 6'b000000, 0, 0, 0, 32'h0,        32'd0};
        vecs[1]  = '{1, 6'b000100, 0, 32'h0,        6'b000000, 6'b000000, 6'b000000, 0, 0, 0, 32'h0,        32'd0};
        vecs[2]  = '{0, 6'b000000, 0, 32'h0,        6'b000000, 6'b000000, 6'b000000, 0, 0, 0, 32'h0,        32'd0};
        vecs[3]  = '{0, 6'b000100, 0, 32'h0,        6'b000111, 6'b001000, 6'b000000, 0, 0, 0, 32'h0,        32'd0};
        vecs[4]  = '{0, 6'b000100, 0, 32'h0,        6'b000111, 6'b001000, 6'b000000, 0, 0, 0, 32'h0,        32'd1};
        vecs[5]  = '{0, 6'b000100, 0, 32'h0,        6'b000111, 6'b001000, 6'b000000, 0, 0, 0, 32'h0,        32'd2};
        vecs[6]  = '{0, 6'b001100, 0, 32'h0,        6'b001111, 6'b010000, 6'b000000, 0, 0, 0, 32'h0,        32'd3};
        vecs[7]  = '{0, 6'b000000, 0, 32'h0,        6'b000000, 6'b000000, 6'b000000, 0, 0, 0, 32'h0,        32'd4};
        vecs[8]  = '{0, 6'b001000, 1, 32'h80000040, 6'b001111, 6'b010000, 6'b000000, 0, 0, 0, 32'h0,        32'd4};
        vecs[9]  = '{0, 6'b001000, 1, 32'h1234,     6'b000000, 6'b000000, 6'b011111, 1, 1, 0, 32'h80000040, 32'd5};
        vecs[10] = '{0, 6'b000000, 1, 32'h1234,     6'b000000, 6'b000000, 6'b011111, 0, 1, 0, 32'h80000040, 32'd5};
        vecs[11] = '{0, 6'b000000, 0, 32'h0,        6'b000000, 6'b000000, 6'b000000, 0, 0, 0, 32'h80000040, 32'd5};
        vecs[12] = '{0, 6'b000000, 1, 32'hABCD0000, 6'b000000, 6'b000000, 6'b000000, 0, 0, 0, 32'h80000040, 32'd5};
        vecs[13] = '{1, 6'b000000, 0, 32'h0,        6'b000000, 6'b000000, 6'b000000, 0, 0, 0, 32'h0,        32'd0};
        vecs[14] = '{0, 6'b000000, 0, 32'h0,        6'b000000, 6'b000000, 6'b000000, 0, 0, 0, 32'h0,        32'd0};
        @(posedge clk);
        #1;
        foreach (vecs[k]) begin
            drive(vecs[k].r, vecs[k].req, vecs[k].fr, vecs[k].tgt);
            #1;
            chk($sformatf("v%0d_stall", k), bus.stall, vecs[k].st);
            chk($sformatf("v%0d_bubble", k), bus.bubble, vecs[k].bu);
            chk($sformatf("v%0d_flush", k), bus.flush, vecs[k].fl);
            chk($sformatf("v%0d_redirect_valid", k), bus.redirect_valid, vecs[k].rv);
            chk($sformatf("v%0d_busy", k), bus.busy_flushing, vecs[k].bz);
            chk($sformatf("v%0d_deadlock", k), bus.deadlock, vecs[k].dl);
            chk($sformatf("v%0d_redirect_pc", k), bus.redirect_pc, vecs[k].pc);
            chk($sformatf("v%0d_stall_cycles", k), bus.stall_cycles, vecs[k].cnt);
            tick();
        end
        // watchdog trips on the 8th consecutive stalled edge and stays set
        drive(1'b0, 6'b000010, 1'b0, '0);
        for (int i = 0; i < LIM; i++) begin
            #1;
            chk("wdog_pre", bus.deadlock, 1'b0);
            tick();
        end
        chk("wdog_trip", bus.deadlock, 1'b1);
        drive(1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wdog_sticky", bus.deadlock, 1'b1);
        end
        drive(1'b1, '0, 1'b0, '0);
        tick();
        drive(1'b0, '0, 1'b0, '0);
        #1;
        chk("wdog_rst_clear", bus.deadlock, 1'b0);
        // a single free cycle between two 7-cycle runs restarts the count
        for (int j = 0; j < 15; j++) begin
            drive(1'b0, (j == 7) ? 6'b0 : 6'b100000, 1'b0, '0);
            #1;
            chk("wdog_gap_stall", bus.stall, (j == 7) ? 6'b0 : 6'b111111);
            tick();
        end
        drive(1'b0, '0, 1'b0, '0);
        #1;
        chk("wdog_gap_none", bus.deadlock, 1'b0);
        chk("wdog_gap_cnt", bus.stall_cycles, 32'd14);
        check_model();
        tick();
        // randomized run against the model
        for (int i = 0; i < 600; i++) begin
            logic [5:0] req = bus.stall_req;
            if ($urandom_range(0, 3) == 0) req = 6'($urandom & $urandom & $urandom);
            drive($urandom_range(0, 149) == 0, req, $urandom_range(0, 11) == 0, $urandom);
            #1;
            check_model();
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl_n.md
Name: pipeline_ctrl_n

Overview:
Parametrised pipeline hazard controller for an N-stage in-order core. Stage 0 is the PC and stage N-1 is WB.
- Merges per-stage stall requests into a stall vector; a request from stage k freezes stages 0..k.
- Marks bubble-insertion points.
- Runs a registered flush sequence that redirects the PC.
- Provides a stall watchdog and a stall-cycle counter.
- Sits beside the datapath and drives every pipeline register's stall/flush enables.

Parameters:
- NUM_STAGES, 6, pipeline stage count including PC (stage 0) and WB (stage N-1); legal range 3..16.
- ADDR_W, 32, width of the redirect PC.
- FLUSH_CYCLES, 1, cycles the flush vector is held; legal range 1..15.
- WDOG_LIMIT, 1024, consecutive stalled cycles before the deadlock flag sets; 0 disables the watchdog.
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- stall_req  in  NUM_STAGES  bit k = stage k requests a stall
- flush_req  in  1  exception/branch-mispredict flush request
- flush_target  in  ADDR_W  redirect PC; sampled together with flush_req
- stall  out  NUM_STAGES  bit k = freeze pipeline register of stage k
- bubble  out  NUM_STAGES  bit k = stage k loads a NOP (stage k-1 is stalled and k is not)
- flush  out  NUM_STAGES  bit k = clear stage k register
- redirect_valid  out  1  PC must load redirect_pc this cycle
- redirect_pc  out  ADDR_W  captured flush_target
- busy_flushing  out  1  FSM is in FLUSH state
- deadlock  out  1  sticky watchdog flag
- stall_cycles  out  CNT_W  count of cycles with stall != 0

Behaviour:
- Reset (rst=1 at a clock edge): FSM goes to RUN; flush counter, watchdog counter, stall_cycles, deadlock and redirect_pc all clear to 0.
  - While rst=1, all outputs are forced to 0, combinationally.
- Stall merge in RUN (combinational, zero latency):
  - h = highest index with stall_req[h]=1.
  - stall[i] = 1 for i <= h, else 0.
  - No requests gives stall = 0.
  - stall_req[N-1] is legal and stalls every stage.
  - Example, N=6: EX (stage 3) request gives 001111; ID (stage 2) request gives 000111; both gives 001111.
- Bubble: bubble[0] = 0; for k >= 1, bubble[k] = stall[k-1] & ~stall[k]. bubble is forced to 0 outside RUN.
- FSM states RUN and FLUSH.
  - RUN to FLUSH: at the edge where flush_req=1.
    - redirect_pc <= flush_target.
    - flush counter <= FLUSH_CYCLES-1.
    - The stall/bubble outputs of that cycle still follow stall_req, so flush latency is 1 cycle.
  - In FLUSH:
    - flush[i] = 1 for i = 0..N-2; flush[N-1] = 0, so WB retires.
    - stall = 0 and bubble = 0; stall_req is ignored.
    - busy_flushing = 1.
    - redirect_valid = 1 only in the first FLUSH cycle.
    - If counter = 0, go to RUN at the next edge; otherwise decrement.
  - flush_req while in FLUSH is ignored and not queued; the source must hold or re-issue it after busy_flushing falls.
  - In RUN: flush = 0, redirect_valid = 0, busy_flushing = 0.
- Watchdog:
  - wcnt increments (saturating at WDOG_LIMIT) each cycle with stall != 0; it clears on any cycle with stall = 0 and in FLUSH.
  - deadlock sets at the edge where wcnt reaches WDOG_LIMIT and stays set until rst.
  - With WDOG_LIMIT=0, deadlock stays 0.
- stall_cycles: +1 on every cycle with stall != 0, wrapping modulo 2^CNT_W; no saturation.
- rst asserted mid-flush aborts the flush: the next cycle is in RUN with all outputs at 0.

Decomposition:
- Shared package (global defines): FSM state encodings ST_RUN and ST_FLUSH, stage-index constants (STG_PC=0, STG_IF, STG_ID, STG_EX, STG_MEM, STG_WB) for the default N=6, and STOP/NO_STOP.
- Sub-module stall_mask_gen (NUM_STAGES): purely combinational; takes stall_req, produces the prefix stall mask and the bubble vector.
- The FSM, watchdog and counter stay in the top module.

Test Plan:
- N=6; rst held 2 cycles, then release with no requests -> all outputs 0, stall_cycles=0.
- stall_req=000100 (stage 2) for 3 cycles, then 001100 -> stall=000111 with bubble=001000; then stall=001111 with bubble=010000; stall_cycles=4 after the 4th stalled cycle.
- FLUSH_CYCLES=2; flush_req=1 with flush_target=0x8000_0040 while stall_req=001000 -> that cycle stall=001111. Next cycle: flush=011111, redirect_valid=1, redirect_pc=0x8000_0040. Following cycle: flush=011111, redirect_valid=0. Then back in RUN with flush=0.
- Second flush_req during FLUSH with flush_target=0x1234 -> ignored; redirect_pc stays 0x8000_0040; no extra FLUSH cycles.
- WDOG_LIMIT=8; stall_req=000010 held 8 cycles -> deadlock=1 after the 8th edge and stays 1 after requests drop. Separately, 7 stalled cycles, one free cycle, then 7 more -> deadlock stays 0.
- rst asserted in the first FLUSH cycle -> next cycle: flush=0, busy_flushing=0, redirect_pc=0, deadlock=0.
